// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// and buffered MULT/DIV results, which may each need two writes.
module regfile_wb_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int LS_ADDR    = 61,
    parameter int QUO_ADDR   = 62,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regReq,
    input  logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    input  logic              mdValid,
    input  logic [1:0]        mdType,
    input  logic [ADDR_W-1:0] mdAddr,
    input  logic [DATA_W-1:0] mdLo,
    input  logic [DATA_W-1:0] mdHi,
    output logic              mdReady,
    output logic              wrEnable,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              busy,
    output logic [2:0]        pendingCount
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] T_MULT = 2'b01;
    localparam logic [1:0] T_DIV  = 2'b10;

    typedef struct packed {
        logic [1:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
    } md_entry_t;

    // Phase 0 is issued directly from IDLE, so only the pending second write needs a state.
    typedef enum logic {IDLE, PH1} state_t;

    md_entry_t         mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     cnt;
    state_t            state, state_nxt;
    md_entry_t         head;
    logic              push, pop, nonempty, two_phase;
    logic              g_en;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    assign mdReady      = cnt < CW'(FIFO_DEPTH);
    assign push         = mdValid && mdReady;
    assign nonempty     = cnt != '0;
    assign head         = mem[rd_ptr];
    assign two_phase    = (head.typ == T_MULT) || (head.typ == T_DIV);
    assign busy         = nonempty || (state != IDLE);
    assign pendingCount = 3'(cnt);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{typ: mdType, addr: mdAddr, lo: mdLo, hi: mdHi};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Pipeline grant freezes the drain sequence.
    always_comb begin
        state_nxt = state;
        if (!regReq) begin
            if (state == PH1)               state_nxt = IDLE;
            else if (nonempty && two_phase) state_nxt = PH1;
        end
    end

    always_comb begin
        g_en   = 1'b0;
        g_addr = '0;
        g_data = '0;
        pop    = 1'b0;
        if (regReq) begin
            g_en   = 1'b1;
            g_addr = regAddr;
            g_data = regData;
        end else if (state == PH1) begin
            g_en   = 1'b1;
            pop    = 1'b1;
            g_data = head.hi;
            g_addr = (head.typ == T_MULT) ? ADDR_W'(LS_ADDR) : head.addr;
        end else if (nonempty) begin
            g_en   = 1'b1;
            pop    = !two_phase;
            g_data = head.lo;
            g_addr = (head.typ == T_DIV) ? ADDR_W'(QUO_ADDR) : head.addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrEnable <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
        end else begin
            wrEnable <= g_en;
            if (g_en) begin
                wrAddr <= g_addr;
                wrData <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a queue of expected register writes.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regReq = 1'b0;
    logic [5:0]  regAddr = '0;
    logic [31:0] regData = '0;
    logic        mdValid = 1'b0;
    logic [1:0]  mdType = '0;
    logic [5:0]  mdAddr = '0;
    logic [31:0] mdLo = '0;
    logic [31:0] mdHi = '0;
    logic        mdReady, wrEnable, busy;
    logic [5:0]  wrAddr;
    logic [31:0] wrData;
    logic [2:0]  pendingCount;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset), .regReq(regReq), .regAddr(regAddr), .regData(regData),
        .mdValid(mdValid), .mdType(mdType), .mdAddr(mdAddr), .mdLo(mdLo), .mdHi(mdHi),
        .mdReady(mdReady), .wrEnable(wrEnable), .wrAddr(wrAddr), .wrData(wrData),
        .busy(busy), .pendingCount(pendingCount)
    );

    always #5 clk = ~clk;

    // Model: every accepted result is expanded into its writes; entries counts results held.
    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        bit          last;
    } wr_t;
    wr_t         q[$];
    int          ent = 0;
    logic [37:0] wlog[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rq, input logic [5:0] ra, input logic [31:0] rd,
                       input bit mv, input logic [1:0] mt, input logic [5:0] ma,
                       input logic [31:0] lo, input logic [31:0] hi);
        bit          acc, ee;
        logic [5:0]  ea;
        logic [31:0] ed;
        wr_t         w;
        regReq = rq; regAddr = ra; regData = rd;
        mdValid = mv; mdType = mt; mdAddr = ma; mdLo = lo; mdHi = hi;
        #1;
        chk("mdReady", 64'(mdReady), 64'(ent < 4));
        chk("pendingCount", 64'(pendingCount), 64'(ent));
        chk("busy", 64'(busy), 64'(ent != 0));
        acc = mv && (ent < 4);
        ee = 1'b0; ea = '0; ed = '0;
        if (rq) begin
            ee = 1'b1; ea = ra; ed = rd;
        end else if (q.size() > 0) begin
            w = q.pop_front();
            ee = 1'b1; ea = w.a; ed = w.d;
            if (w.last) ent--;
        end
        if (acc) begin
            ent++;
            case (mt)
                2'b01: begin
                    q.push_back('{a: ma, d: lo, last: 1'b0});
                    q.push_back('{a: 6'd61, d: hi, last: 1'b1});
                end
                2'b10: begin
                    q.push_back('{a: 6'd62, d: lo, last: 1'b0});
                    q.push_back('{a: ma, d: hi, last: 1'b1});
                end
                default: q.push_back('{a: ma, d: lo, last: 1'b1});
            endcase
        end
        @(posedge clk);
        #1;
        chk("wrEnable", 64'(wrEnable), 64'(ee));
        if (ee) begin
            chk("wrAddr", 64'(wrAddr), 64'(ea));
            chk("wrData", 64'(wrData), 64'(ed));
        end
        if (wrEnable) wlog.push_back({wrAddr, wrData});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #12;
        chk("rst wrEnable", 64'(wrEnable), 64'd0);
        chk("rst wrAddr", 64'(wrAddr), 64'd0);
        chk("rst wrData", 64'(wrData), 64'd0);
        chk("rst pendingCount", 64'(pendingCount), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst mdReady", 64'(mdReady), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // pipeline-only write
        wlog.delete();
        cyc(1, 6'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle(1);
        chk("pipe count", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) chk("pipe write", 64'(wlog[0]), {26'd0, 6'd5, 32'hDEADBEEF});

        // MULT result
        wlog.delete();
        cyc(0, 0, 0, 1, 2'b01, 6'd7, 32'h11111111, 32'h22222222);
        idle(3);
        chk("mult count", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("mult lo", 64'(wlog[0]), {26'd0, 6'd7, 32'h11111111});
            chk("mult hi", 64'(wlog[1]), {26'd0, 6'd61, 32'h22222222});
        end
        chk("mult busy", 64'(busy), 64'd0);

        // DIV colliding with pipeline writes
        wlog.delete();
        cyc(1, 6'd4, 32'h44, 1, 2'b10, 6'd9, 32'd3, 32'd1);
        cyc(1, 6'd4, 32'h45, 0, 0, 0, 0, 0);
        idle(3);
        chk("div count", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            chk("div pipe0", 64'(wlog[0]), {26'd0, 6'd4, 32'h44});
            chk("div pipe1", 64'(wlog[1]), {26'd0, 6'd4, 32'h45});
            chk("div quo", 64'(wlog[2]), {26'd0, 6'd62, 32'd3});
            chk("div rem", 64'(wlog[3]), {26'd0, 6'd9, 32'd1});
        end

        // backpressure: fifth push is refused while full
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk("full pending", 64'(pendingCount), 64'd4);
                chk("full mdReady", 64'(mdReady), 64'd0);
            end
            cyc(1, 6'd4, 32'(i), 1, 2'b01, 6'(10 + i), 32'h100 + 32'(i), 32'h200 + 32'(i));
        end
        chk("full pending after", 64'(pendingCount), 64'd4);
        wlog.delete();
        idle(1);
        chk("ready before pop", 64'(mdReady), 64'd0);
        idle(1);
        chk("ready after pop", 64'(mdReady), 64'd1);
        idle(7);
        chk("drain count", 64'(wlog.size()), 64'd8);
        if (wlog.size() == 8)
            for (int k = 0; k < 4; k++) begin
                chk("drain lo", 64'(wlog[2*k]), {26'd0, 6'(10 + k), 32'h100 + 32'(k)});
                chk("drain hi", 64'(wlog[2*k+1]), {26'd0, 6'd61, 32'h200 + 32'(k)});
            end
        chk("drain busy", 64'(busy), 64'd0);

        // reset in the middle of a MULT sequence
        cyc(0, 0, 0, 1, 2'b01, 6'd20, 32'hAAAA, 32'hBBBB);
        idle(1);
        reset = 1'b1;
        #1;
        chk("mid rst wrEnable", 64'(wrEnable), 64'd0);
        chk("mid rst pending", 64'(pendingCount), 64'd0);
        chk("mid rst busy", 64'(busy), 64'd0);
        q.delete();
        ent = 0;
        @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        idle(3);
        chk("post rst writes", 64'(wlog.size()), 64'd0);

        // MULT targeting the LS register itself
        wlog.delete();
        cyc(0, 0, 0, 1, 2'b01, 6'd61, 32'hA, 32'hB);
        idle(2);
        chk("overlap count", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("overlap first", 64'(wlog[0]), {26'd0, 6'd61, 32'hA});
            chk("overlap second", 64'(wlog[1]), {26'd0, 6'd61, 32'hB});
        end

        // random traffic; the second half leans on the pipeline to fill the FIFO
        for (int i = 0; i < 800; i++) begin
            bit          rq, mv;
            logic [5:0]  ma;
            rq = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            mv = $urandom_range(0, 1) == 1;
            ma = ($urandom_range(0, 7) == 0) ? 6'(61 + $urandom_range(0, 1)) : 6'($urandom_range(0, 63));
            cyc(rq, 6'($urandom_range(0, 63)), $urandom, mv, 2'($urandom_range(0, 3)), ma,
                $urandom, $urandom);
        end
        idle(12);
        chk("final busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Schedules the single register-file write port (write enable / write address / write data) between two sources.
- Source 1: the main pipeline's single-cycle writeback.
- Source 2: results from the multi-cycle MULT/DIV unit. Each result may need two register writes (destination plus LS or QUO special register).
- Buffers multi-cycle results in a small FIFO and sequences them into one write per cycle, with pipeline writes always taking priority.

Parameters:
- ADDR_W, 6, register address width
- DATA_W, 32, register data width
- LS_ADDR, 61, register receiving the MULT high word
- QUO_ADDR, 62, register receiving the DIV quotient
- FIFO_DEPTH, 4, MULT/DIV result entries buffered (power of two, >=2)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- regReq  input  1  pipeline writeback request (no backpressure, always granted)
- regAddr  input  ADDR_W  pipeline destination register
- regData  input  DATA_W  pipeline write data
- mdValid  input  1  MULT/DIV result valid
- mdType  input  2  00 REGULAR, 01 MULT, 10 DIV, 11 reserved
- mdAddr  input  ADDR_W  MULT/DIV destination register
- mdLo  input  DATA_W  MULT low word / DIV quotient / REGULAR data
- mdHi  input  DATA_W  MULT high word / DIV remainder
- mdReady  output  1  FIFO can accept an entry this cycle
- wrEnable  output  1  register-file write enable
- wrAddr  output  ADDR_W  register-file write address
- wrData  output  DATA_W  register-file write data
- busy  output  1  FIFO non-empty or drain FSM not IDLE
- pendingCount  output  3  entries currently in the FIFO

Behaviour:
- Reset (asynchronous):
  - wrEnable=0, wrAddr=0, wrData=0.
  - FIFO emptied; pendingCount=0; FSM=IDLE; busy=0; mdReady=1.
  - Reset mid-sequence discards all pending MULT/DIV results with no partial writes after reset asserts.
- Outputs:
  - wrEnable, wrAddr and wrData are registered: a grant decided in cycle t appears at the posedge ending t.
  - The register file commits on the following negedge, so write data is stable for half a cycle before commit.
  - At most one write per cycle.
- Handshake:
  - mdReady = (pendingCount < FIFO_DEPTH), combinational from the count only.
  - Push occurs when mdValid && mdReady; an entry is {mdType, mdAddr, mdLo, mdHi}.
  - When full, mdReady=0 even if a pop happens in the same cycle.
  - Push and pop in the same non-full cycle leave the count unchanged.
- Priority:
  - regReq=1 grants the pipeline: wrAddr<=regAddr, wrData<=regData, wrEnable<=1.
  - The drain FSM holds state that cycle; no phase advances.
- Drain FSM (acts only when regReq=0):
  - IDLE: if FIFO non-empty, go to PH0 in the same cycle and issue the phase-0 write of the head entry; else wrEnable<=0.
  - PH0 write by type:
    - REGULAR or reserved(11): mdLo -> mdAddr.
    - MULT: mdLo -> mdAddr.
    - DIV: mdLo -> QUO_ADDR.
  - After PH0:
    - REGULAR/reserved: pop the entry, return to IDLE.
    - MULT/DIV: go to PH1.
  - PH1 write by type:
    - MULT: mdHi -> LS_ADDR.
    - DIV: mdHi -> mdAddr.
  - After PH1: pop, then go to IDLE, or straight into PH0 of the next entry if the FIFO is still non-empty, giving back-to-back writes.
- Boundaries:
  - With no pipeline traffic, a MULT entry accepted at cycle t yields writes at t+1 and t+2. A stream of MULT entries sustains one write per cycle.
  - A continuous regReq starves the FIFO indefinitely; this is intended. The pipeline stalls on mdReady=0.
  - mdAddr equal to LS_ADDR (MULT) or QUO_ADDR (DIV): both writes are still issued in phase order, so the second write value is final.
  - The FIFO preserves write ordering among MULT/DIV entries. Ordering between pipeline and MULT/DIV writes is grant order; RAW/WAW hazard avoidance belongs to the hazard unit, not this block.
  - pendingCount wraps never; it saturates structurally at FIFO_DEPTH.
- busy = (pendingCount!=0) || (FSM!=IDLE).

Test Plan:
- Pipeline-only write: regReq=1, regAddr=5, regData=0xDEADBEEF for one cycle -> next posedge wrEnable=1, wrAddr=5, wrData=0xDEADBEEF; following cycle wrEnable=0.
- MULT result: push mdType=01, mdAddr=7, mdLo=0x11111111, mdHi=0x22222222 with regReq=0 -> write 7<=0x11111111, then 61<=0x22222222 on consecutive cycles; busy then drops to 0.
- DIV with pipeline collision: push DIV mdAddr=9, mdLo=3, mdHi=1; hold regReq=1 (addr 4) for 2 cycles -> two pipeline writes to 4 first, then 62<=3, then 9<=1.
- Backpressure: hold regReq=1 and push 4 MULT entries -> pendingCount=4 and mdReady=0; a 5th mdValid is not accepted. Release regReq -> 8 back-to-back writes in FIFO order; mdReady rises after the first pop.
- Reset mid-drain: assert reset during PH0 of a MULT entry -> wrEnable=0 immediately (asynchronous), pendingCount=0, no LS_ADDR write after reset deasserts.
- Special-address overlap: MULT with mdAddr=61, mdLo=0xA, mdHi=0xB -> writes 61<=0xA then 61<=0xB.
